// File: rtl/rv_iopmp_error_arbiter.sv
// Error arbiter for IOPMP matching instances: buffers one report per instance,
// drains the buffers round-robin into the shared ERR_REQ* register set, and
// raises the error interrupt while a captured error is pending in software.

package rv_iopmp_error_arbiter_pkg;

    typedef struct packed {
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [15:0] sid;
        logic [15:0] eid;
        logic [63:0] addr;
    } err_payload_t;

    typedef struct packed {
        logic         error_detected;
        err_payload_t payload;
    } error_capture_t;

    typedef struct packed {
        struct packed { logic q; } ip;
    } iopmp_reg2hw_err_reqinfo_reg_t;

    typedef struct packed {
        struct packed { logic       d; logic de; } ip;
        struct packed { logic [1:0] d; logic de; } ttype;
        struct packed { logic [2:0] d; logic de; } etype;
    } iopmp_hw2reg_err_reqinfo_reg_t;

    typedef struct packed {
        struct packed { logic [15:0] d; logic de; } sid;
        struct packed { logic [15:0] d; logic de; } eid;
    } iopmp_hw2reg_err_reqid_reg_t;

    typedef struct packed {
        logic [31:0] d;
        logic        de;
    } iopmp_hw2reg_err_reqaddr_reg_t;

    typedef struct packed {
        logic [31:0] d;
        logic        de;
    } iopmp_hw2reg_err_reqaddrh_reg_t;

endpackage

module rv_iopmp_error_arbiter
    import rv_iopmp_error_arbiter_pkg::*;
#(
    parameter int unsigned NUMBER_IOPMP_INSTANCES = 1,
    parameter int unsigned DROP_CNT_W             = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  error_capture_t                 err_interface_i [NUMBER_IOPMP_INSTANCES],
    output logic [NUMBER_IOPMP_INSTANCES-1:0] err_ready_o,
    input  iopmp_reg2hw_err_reqinfo_reg_t  reg2hw_err_reqinfo_i,
    input  logic                           ie_i,
    output iopmp_hw2reg_err_reqinfo_reg_t  hw2reg_err_reqinfo_o,
    output iopmp_hw2reg_err_reqid_reg_t    hw2reg_err_reqid_o,
    output iopmp_hw2reg_err_reqaddr_reg_t  hw2reg_err_reqaddr_o,
    output iopmp_hw2reg_err_reqaddrh_reg_t hw2reg_err_reqaddrh_o,
    output logic                           irq_o,
    output logic [DROP_CNT_W-1:0]          drop_cnt_o,
    output logic                           busy_o
);

    localparam int unsigned N      = NUMBER_IOPMP_INSTANCES;
    localparam int unsigned PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PCNT_W = $clog2(N + 1);
    localparam int unsigned SUM_W  = DROP_CNT_W + PCNT_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - DROP_CNT_W){1'b0}}, {DROP_CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        slot_valid_q, slot_valid_d;
    err_payload_t        slot_q [N];
    err_payload_t        slot_d [N];
    err_payload_t        payload_q, payload_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    winner_q, winner_d;
    logic [PTR_W-1:0]    winner_c;
    logic [PTR_W-1:0]    rr_next;
    logic                any_valid;
    logic                commit_fire;
    logic [N-1:0]        drop_vec;
    logic [PCNT_W-1:0]   drop_num;
    logic [SUM_W-1:0]    drop_sum;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                irq_q, irq_d;
    logic                ip;

    assign ip          = reg2hw_err_reqinfo_i.ip.q;
    assign irq_o       = irq_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign busy_o      = (|slot_valid_q) | (state_q != IDLE);
    assign rr_next     = (winner_q == PTR_W'(N - 1)) ? '0 : winner_q + 1'b1;

    // Round-robin pick: slots at or above rr_ptr first, then wrap to the low slots.
    always_comb begin
        winner_c  = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_valid && slot_valid_q[i] && (i >= 32'(rr_ptr_q))) begin
                any_valid = 1'b1;
                winner_c  = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_valid && slot_valid_q[i]) begin
                any_valid = 1'b1;
                winner_c  = PTR_W'(i);
            end
        end
    end

    // Slot fill/drain and drop counting; a drained slot may be refilled in the same cycle.
    always_comb begin
        drop_num = '0;
        for (int unsigned i = 0; i < N; i++) begin
            err_ready_o[i]  = ~slot_valid_q[i] | (commit_fire & (winner_q == PTR_W'(i)));
            drop_vec[i]     = err_interface_i[i].error_detected & ~err_ready_o[i];
            slot_valid_d[i] = slot_valid_q[i];
            slot_d[i]       = slot_q[i];
            if (commit_fire && (winner_q == PTR_W'(i))) begin
                slot_valid_d[i] = 1'b0;
            end
            if (err_interface_i[i].error_detected && err_ready_o[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_d[i]       = err_interface_i[i].payload;
            end
            drop_num = drop_num + PCNT_W'(drop_vec[i]);
        end
        drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(drop_num);
        drop_cnt_d = (drop_sum > CNT_MAX) ? '1 : DROP_CNT_W'(drop_sum);
    end

    // Commit FSM next state and hw2reg write strobes.
    always_comb begin
        state_d               = state_q;
        payload_d             = payload_q;
        winner_d              = winner_q;
        rr_ptr_d              = rr_ptr_q;
        commit_fire           = 1'b0;
        hw2reg_err_reqinfo_o  = '0;
        hw2reg_err_reqid_o    = '0;
        hw2reg_err_reqaddr_o  = '0;
        hw2reg_err_reqaddrh_o = '0;
        unique case (state_q)
            IDLE: begin
                if (ip) begin
                    state_d = HOLD;
                end else if (any_valid) begin
                    winner_d = winner_c;
                    for (int unsigned i = 0; i < N; i++) begin
                        if (winner_c == PTR_W'(i)) begin
                            payload_d = slot_q[i];
                        end
                    end
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit_fire                   = 1'b1;
                hw2reg_err_reqinfo_o.ip.de    = 1'b1;
                hw2reg_err_reqinfo_o.ip.d     = 1'b1;
                hw2reg_err_reqinfo_o.ttype.de = 1'b1;
                hw2reg_err_reqinfo_o.ttype.d  = payload_q.ttype;
                hw2reg_err_reqinfo_o.etype.de = 1'b1;
                hw2reg_err_reqinfo_o.etype.d  = payload_q.etype;
                hw2reg_err_reqid_o.sid.de     = 1'b1;
                hw2reg_err_reqid_o.sid.d      = payload_q.sid;
                hw2reg_err_reqid_o.eid.de     = 1'b1;
                hw2reg_err_reqid_o.eid.d      = payload_q.eid;
                hw2reg_err_reqaddr_o.de       = 1'b1;
                hw2reg_err_reqaddr_o.d        = payload_q.addr[31:0];
                hw2reg_err_reqaddrh_o.de      = 1'b1;
                hw2reg_err_reqaddrh_o.d       = payload_q.addr[63:32];
                rr_ptr_d                      = rr_next;
                state_d                       = HOLD;
            end
            HOLD: begin
                if (!ip) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        irq_d = ie_i & (state_q == HOLD) & ip;
    end

    // State, slot and counter registers; reset discards held slots and any in-flight commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            slot_valid_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
            payload_q    <= '0;
            rr_ptr_q     <= '0;
            winner_q     <= '0;
            drop_cnt_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            for (int unsigned i = 0; i < N; i++) begin
                slot_q[i] <= slot_d[i];
            end
            payload_q    <= payload_d;
            rr_ptr_q     <= rr_ptr_d;
            winner_q     <= winner_d;
            drop_cnt_q   <= drop_cnt_d;
            irq_q        <= irq_d;
        end
    end

endmodule

// File: tb/tb_rv_iopmp_error_arbiter.sv
// Directed bench for rv_iopmp_error_arbiter with a minimal ERR_REQINFO.ip model.

module tb_rv_iopmp_error_arbiter;
    import rv_iopmp_error_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 2;

    logic                           clk;
    logic                           rst;
    error_capture_t                 err_if [N];
    logic [N-1:0]                   err_ready;
    iopmp_reg2hw_err_reqinfo_reg_t  reg2hw_info;
    logic                           ie;
    iopmp_hw2reg_err_reqinfo_reg_t  hw_info;
    iopmp_hw2reg_err_reqid_reg_t    hw_id;
    iopmp_hw2reg_err_reqaddr_reg_t  hw_addr;
    iopmp_hw2reg_err_reqaddrh_reg_t hw_addrh;
    logic                           irq;
    logic [DW-1:0]                  drop_cnt;
    logic                           busy;

    logic ip_q;
    logic sw_clear;
    logic sw_set;

    int n_checks;
    int n_fail;

    rv_iopmp_error_arbiter #(
        .NUMBER_IOPMP_INSTANCES(N),
        .DROP_CNT_W            (DW)
    ) u_dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .err_interface_i      (err_if),
        .err_ready_o          (err_ready),
        .reg2hw_err_reqinfo_i (reg2hw_info),
        .ie_i                 (ie),
        .hw2reg_err_reqinfo_o (hw_info),
        .hw2reg_err_reqid_o   (hw_id),
        .hw2reg_err_reqaddr_o (hw_addr),
        .hw2reg_err_reqaddrh_o(hw_addrh),
        .irq_o                (irq),
        .drop_cnt_o           (drop_cnt),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Software-visible ip bit: hardware write wins over software clear/set.
    always @(posedge clk or posedge rst) begin
        if (rst)                 ip_q <= 1'b0;
        else if (hw_info.ip.de)  ip_q <= hw_info.ip.d;
        else if (sw_clear)       ip_q <= 1'b0;
        else if (sw_set)         ip_q <= 1'b1;
    end
    assign reg2hw_info.ip.q = ip_q;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic error_capture_t rep(input logic [15:0] sid, input logic [15:0] eid,
                                           input logic [63:0] addr, input logic [1:0] tt,
                                           input logic [2:0] et);
        error_capture_t r;
        r.error_detected = 1'b1;
        r.payload.sid    = sid;
        r.payload.eid    = eid;
        r.payload.addr   = addr;
        r.payload.ttype  = tt;
        r.payload.etype  = et;
        return r;
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < int'(N); i++) err_if[i] = '0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, 64'(|{hw_info, hw_id, hw_addr, hw_addrh}), 64'd0);
    endtask

    task automatic check_commit(input string tag, input logic [15:0] sid, input logic [15:0] eid,
                                input logic [63:0] addr, input logic [1:0] tt, input logic [2:0] et);
        check_eq({tag, ".de"}, 64'({hw_info.ip.de, hw_info.ttype.de, hw_info.etype.de,
                                    hw_id.sid.de, hw_id.eid.de, hw_addr.de, hw_addrh.de}), 64'h7f);
        check_eq({tag, ".ip"},    64'(hw_info.ip.d),    64'd1);
        check_eq({tag, ".ttype"}, 64'(hw_info.ttype.d), 64'(tt));
        check_eq({tag, ".etype"}, 64'(hw_info.etype.d), 64'(et));
        check_eq({tag, ".sid"},   64'(hw_id.sid.d),     64'(sid));
        check_eq({tag, ".eid"},   64'(hw_id.eid.d),     64'(eid));
        check_eq({tag, ".addr"},  64'({hw_addrh.d, hw_addr.d}), addr);
    endtask

    task automatic clear_ip();
        sw_clear = 1'b1;
        tick();
        sw_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ie       = 1'b1;
        sw_clear = 1'b0;
        sw_set   = 1'b0;
        idle_inputs();
        tick();
        mid();
        check_eq("rst.quiet", 64'(|{hw_info, hw_id, hw_addr, hw_addrh}), 64'd0);
        check_eq("rst.ready", 64'(err_ready), 64'hf);
        check_eq("rst.busy",  64'(busy), 64'd0);
        check_eq("rst.irq",   64'(irq), 64'd0);
        check_eq("rst.drop",  64'(drop_cnt), 64'd0);
        tick();
        rst = 1'b0;

        // Single error on instance 0; cycle t is the report cycle.
        tick();
        err_if[0] = rep(16'd3, 16'd5, 64'h1000_0040, 2'd1, 3'd2);
        mid();
        check_eq("t1.ready_t", 64'(err_ready), 64'hf);
        tick();
        idle_inputs();
        mid();
        check_quiet("t1.quiet_t1");
        check_eq("t1.busy_t1", 64'(busy), 64'd1);
        tick();
        mid();
        check_commit("t1.commit", 16'd3, 16'd5, 64'h1000_0040, 2'd1, 3'd2);
        tick();
        mid();
        check_quiet("t1.quiet_t3");
        check_eq("t1.irq_t3", 64'(irq), 64'd0);
        tick();
        mid();
        check_eq("t1.irq_t4", 64'(irq), 64'd1);
        clear_ip();
        mid();
        check_eq("t1.irq_t5", 64'(irq), 64'd1);
        tick();
        mid();
        check_eq("t1.irq_t6", 64'(irq), 64'd0);
        check_eq("t1.drop", 64'(drop_cnt), 64'd0);

        // Move rr_ptr to 2 by committing instance 1 alone.
        err_if[1] = rep(16'd1, 16'd1, 64'h100, 2'd0, 3'd1);
        tick();
        idle_inputs();
        tick();
        mid();
        check_commit("t2.pre", 16'd1, 16'd1, 64'h100, 2'd0, 3'd1);
        tick();
        clear_ip();
        tick();
        // Instances 1 and 3 together with rr_ptr=2: 3 wins.
        err_if[1] = rep(16'd11, 16'd21, 64'h1100, 2'd2, 3'd3);
        err_if[3] = rep(16'd13, 16'd23, 64'h1300, 2'd3, 3'd4);
        tick();
        idle_inputs();
        tick();
        mid();
        check_commit("t2.first", 16'd13, 16'd23, 64'h1300, 2'd3, 3'd4);
        check_eq("t2.ready", 64'(err_ready), 64'b1101);
        tick();
        tick();
        mid();
        check_quiet("t2.held");
        clear_ip();
        mid();
        check_quiet("t2.clr0");
        tick();
        mid();
        check_quiet("t2.clr1");
        tick();
        mid();
        check_commit("t2.second", 16'd11, 16'd21, 64'h1100, 2'd2, 3'd3);
        tick();
        check_eq("t2.rr", 64'(u_dut.rr_ptr_q), 64'd2);

        // ip=1: instance 2 reports twice, second is dropped.
        err_if[2] = rep(16'd2, 16'd2, 64'hA0, 2'd1, 3'd1);
        mid();
        check_eq("t3.ready0", 64'(err_ready), 64'hf);
        tick();
        err_if[2] = rep(16'd2, 16'd2, 64'hB0, 2'd1, 3'd1);
        mid();
        check_eq("t3.ready1", 64'(err_ready), 64'b1011);
        tick();
        idle_inputs();
        mid();
        check_eq("t3.drop", 64'(drop_cnt), 64'd1);
        tick();
        mid();
        check_quiet("t3.held");
        check_eq("t3.busy", 64'(busy), 64'd1);
        clear_ip();
        mid();
        check_quiet("t3.clr0");
        tick();
        mid();
        check_quiet("t3.clr1");
        tick();
        mid();
        check_commit("t3.commit", 16'd2, 16'd2, 64'hA0, 2'd1, 3'd1);
        tick();
        check_eq("t3.rr", 64'(u_dut.rr_ptr_q), 64'd3);

        // Fill all slots, then four drops at once: counter saturates at 3.
        for (int i = 0; i < int'(N); i++) err_if[i] = rep(16'(64 + i), 16'd0, 64'(i), 2'd0, 3'd0);
        mid();
        check_eq("t4.ready0", 64'(err_ready), 64'hf);
        tick();
        mid();
        check_eq("t4.ready1", 64'(err_ready), 64'h0);
        tick();
        idle_inputs();
        mid();
        check_eq("t4.drop_sat", 64'(drop_cnt), 64'd3);
        check_eq("t4.irq", 64'(irq), 64'd1);

        // Reset in HOLD with four valid slots.
        tick();
        rst = 1'b1;
        #1;
        check_quiet("t5a.quiet");
        check_eq("t5a.ready", 64'(err_ready), 64'hf);
        check_eq("t5a.busy",  64'(busy), 64'd0);
        check_eq("t5a.irq",   64'(irq), 64'd0);
        check_eq("t5a.drop",  64'(drop_cnt), 64'd0);
        check_eq("t5a.rr",    64'(u_dut.rr_ptr_q), 64'd0);
        tick();
        rst = 1'b0;
        // Reset at the start of COMMIT.
        err_if[0] = rep(16'd7, 16'd7, 64'h700, 2'd1, 3'd1);
        tick();
        idle_inputs();
        tick();
        check_eq("t5b.de_before", 64'(hw_info.ip.de), 64'd1);
        rst = 1'b1;
        #1;
        check_quiet("t5b.quiet");
        check_eq("t5b.ready", 64'(err_ready), 64'hf);
        tick();
        rst = 1'b0;
        mid();
        check_eq("t5b.busy", 64'(busy), 64'd0);
        check_eq("t5b.irq",  64'(irq), 64'd0);
        tick();
        tick();
        mid();
        check_quiet("t5b.no_commit");
        check_eq("t5b.busy2", 64'(busy), 64'd0);

        // ip set straight out of reset with a pending report.
        rst    = 1'b1;
        sw_set = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sw_set = 1'b0;
        err_if[0] = rep(16'd6, 16'd9, 64'h6000, 2'd2, 3'd5);
        mid();
        check_quiet("t6.q0");
        tick();
        idle_inputs();
        mid();
        check_quiet("t6.q1");
        check_eq("t6.busy", 64'(busy), 64'd1);
        tick();
        mid();
        check_quiet("t6.q2");
        check_eq("t6.irq", 64'(irq), 64'd1);
        clear_ip();
        mid();
        check_quiet("t6.clr0");
        tick();
        mid();
        check_quiet("t6.clr1");
        tick();
        mid();
        check_commit("t6.commit", 16'd6, 16'd9, 64'h6000, 2'd2, 3'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
